// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from an upstream FIFO and sends each as a start/data(LSB first)/stop serial frame.
// Latency: pop strobe is combinational; tx_o drops to the start bit on the edge after the pop; frame = (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
// Backpressure: never pops while empty_i=1; a new word is taken only in IDLE or on the final stop-bit cycle, so frames run back-to-back.
//
// Ports:
//   clk_i    rising-edge clock
//   reset_i  asynchronous active-low reset
//   empty_i  FIFO empty flag
//   data_i   FIFO head word, valid while empty_i=0
//   read_o   one-cycle pop strobe to the FIFO
//   tx_o     registered serial line, idle high
//   busy_o   registered, high while a frame is in progress
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  empty_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  read_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  bit_end;
  logic                  pop;

  // Last clock of the current serial bit.
  assign bit_end = (baud_q == BAUD_LAST);

  // Pop in IDLE, or on the final stop-bit cycle so the next start bit
  // follows the stop bit with no idle gap. Gated by reset_i so no pop is
  // requested while the block is held in reset.
  assign pop = reset_i && !empty_i &&
               ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

  assign read_o = pop;
  assign tx_o   = tx_q;
  assign busy_o = busy_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    busy_d  = 1'b0;

    if (pop) begin
      // data_i is only looked at here; the frame in flight uses shift_q.
      state_d = S_START;
      baud_d  = '0;
      idx_d   = '0;
      shift_d = data_i;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_d = '0;
          idx_d  = '0;
        end
        S_START: begin
          if (bit_end) begin
            state_d = S_DATA;
            baud_d  = '0;
          end else begin
            baud_d = baud_q + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_STOP;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              // Present the next bit at shift_q[0].
              shift_d = shift_q >> 1;
            end
          end else begin
            baud_d = baud_q + BAUD_ONE;
          end
        end
        S_STOP: begin
          // A back-to-back pop is handled above; reaching here on the last
          // cycle means the FIFO was empty, so return to IDLE.
          if (bit_end) begin
            state_d = S_IDLE;
            baud_d  = '0;
          end else begin
            baud_d = baud_q + BAUD_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          baud_d  = '0;
          idx_d   = '0;
        end
      endcase
    end

    // Line level is computed from the next state so tx_q changes on the
    // same edge as the state and is glitch-free at the pin.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule
